jt49_pcm_out: RTL and testbench

JT49_PCM_OUT -- requirements
Module: jt49_pcm_out

---
 rtl/jt49_pcm_out.sv | 133 +++++++++++++
 tb/tb_jt49_pcm_out.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/jt49_pcm_out.sv
// PSG mix to PCM converter: block-averages the 10-bit unsigned mix, removes
// the DC level with a leaky estimator and queues signed 16-bit samples in a
// small FIFO for a ready/valid consumer.
module jt49_pcm_out #(
   parameter int AVG_LOG2 = 3,
   parameter int DC_SHIFT = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cen,
   input  logic [9:0]  din,
   output logic [15:0] pcm,
   output logic        pcm_valid,
   input  logic        pcm_ready,
   output logic        ovf,
   input  logic        clr_ovf
);

   localparam int AW = 10 + AVG_LOG2;
   localparam int DW = 10 + DC_SHIFT;

   logic [AW-1:0]       acc;
   logic [AW-1:0]       acc_sum;
   logic [AVG_LOG2-1:0] cnt;
   logic                last;
   logic [9:0]          avg;
   logic                avg_stb;

   logic [DW-1:0]       dc;
   logic [DW-1:0]       dc_next;
   logic [9:0]          dc_est;
   logic [10:0]         s;
   logic [15:0]         push_data;

   logic [15:0]         mem [4];
   logic [1:0]          wr_ptr;
   logic [1:0]          rd_ptr;
   logic [2:0]          count;
   logic                full;
   logic                pop;
   logic                push_ok;
   logic                drop;

   // the final sample of a block is added in the same cycle it is divided
   assign acc_sum = acc + AW'(din);
   assign last    = (cnt == {AVG_LOG2{1'b1}});

   // block accumulator; avg_stb pulses for one clk when a block completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         cnt     <= '0;
         avg     <= '0;
         avg_stb <= 1'b0;
      end else begin
         avg_stb <= 1'b0;
         if (cen) begin
            if (last) begin
               avg     <= acc_sum[AW-1:AVG_LOG2];
               acc     <= '0;
               cnt     <= '0;
               avg_stb <= 1'b1;
            end else begin
               acc <= acc_sum;
               cnt <= cnt + AVG_LOG2'(1);
            end
         end
      end
   end

   // both operands are at most 10 bits, so the difference always fits 11 bits signed
   assign dc_est    = dc[DW-1:DC_SHIFT];
   assign s         = {1'b0, avg} - {1'b0, dc_est};
   assign push_data = {s, 5'b0};
   assign dc_next   = dc + DW'(avg) - DW'(dc_est);

   // leaky DC estimator, advanced once per averaged sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dc <= '0;
      end else if (avg_stb) begin
         dc <= dc_next;
      end
   end

   assign full      = (count == 3'd4);
   assign pcm_valid = (count != 3'd0);
   assign pop       = pcm_valid & pcm_ready;
   // a pop on the same edge frees the slot, so a full FIFO can still accept
   assign push_ok   = avg_stb & (~full | pop);
   assign drop      = avg_stb & full & ~pop;
   assign pcm       = pcm_valid ? mem[rd_ptr] : 16'd0;

   // FIFO storage; contents are don't-care while empty since pcm is gated
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         case ({push_ok, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   // sticky overflow; a drop wins over a coincident clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (drop) begin
         ovf <= 1'b1;
      end else if (clr_ovf) begin
         ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_jt49_pcm_out.sv
// Scoreboard bench for jt49_pcm_out (AVG_LOG2=3, DC_SHIFT=8): directed blocks
// push hand-computed PCM values; a negedge monitor compares each accepted
// sample against the queue.
module tb_jt49_pcm_out;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cen = 1'b0;
   logic [9:0]  din = '0;
   logic [15:0] pcm;
   logic        pcm_valid;
   logic        pcm_ready = 1'b0;
   logic        ovf;
   logic        clr_ovf = 1'b0;

   int tests = 0;
   int fails = 0;
   int exp_q[$];

   logic long_mode = 1'b0;
   int   n_long = 0;
   int   neg_cnt = 0;
   int   nonmono = 0;
   int   prev_s = 0;
   int   first_pcm = 0;
   int   last_pcm = 0;

   jt49_pcm_out #(.AVG_LOG2(3), .DC_SHIFT(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cen       (cen),
      .din       (din),
      .pcm       (pcm),
      .pcm_valid (pcm_valid),
      .pcm_ready (pcm_ready),
      .ovf       (ovf),
      .clr_ovf   (clr_ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   // monitor: every sample the consumer accepts is checked
   always @(negedge clk) begin
      if (rst_n && pcm_valid && pcm_ready) begin
         if (long_mode) begin
            int sv;
            sv = int'($signed(pcm)) >>> 5;
            n_long++;
            if (n_long == 1) first_pcm = int'($signed(pcm));
            if (sv < 0) neg_cnt++;
            if (n_long > 1 && sv > prev_s) nonmono++;
            prev_s = sv;
            last_pcm = int'($signed(pcm));
         end else begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_out: got %0d, expected no sample", $signed(pcm));
            end else begin
               int e;
               e = exp_q.pop_front();
               if (int'($signed(pcm)) != e) begin
                  fails++;
                  $display("FAIL pcm_out: got %0d, expected %0d", $signed(pcm), e);
               end
            end
         end
      end
   end

   task automatic check(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input logic [9:0] v);
      cen = 1'b1;
      din = v;
      tick();
      cen = 1'b0;
   endtask

   task automatic block(input logic [9:0] v);
      repeat (8) sample(v);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cen = 1'b0;
      pcm_ready = 1'b0;
      clr_ovf = 1'b0;
      repeat (2) tick();
      check("rst_valid", int'(pcm_valid), 0);
      check("rst_pcm", int'(pcm), 0);
      check("rst_ovf", int'(ovf), 0);
      exp_q.delete();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      // constant 0x100: latency and first DC step
      do_reset();
      pcm_ready = 1'b1;
      repeat (7) sample(10'h100);
      exp_q.push_back(8192);
      sample(10'h100);
      check("lat_e0_valid", int'(pcm_valid), 0);
      tick();
      check("lat_e1_valid", int'(pcm_valid), 1);
      exp_q.push_back(8160);
      block(10'h100);
      repeat (4) tick();
      check("t1_drain", exp_q.size(), 0);

      // ramp 0..7: avg 3
      do_reset();
      pcm_ready = 1'b1;
      exp_q.push_back(96);
      for (int i = 0; i < 8; i++) sample(10'(i));
      repeat (4) tick();
      check("t2_drain", exp_q.size(), 0);

      // consumer stalled: 5 blocks, 5th dropped
      do_reset();
      exp_q.push_back(8192);
      exp_q.push_back(8160);
      exp_q.push_back(2016);
      exp_q.push_back(16320);
      block(10'h100);
      block(10'h100);
      block(10'h040);
      block(10'h200);
      tick();
      check("t3_ovf_before", int'(ovf), 0);
      check("t3_valid_full", int'(pcm_valid), 1);
      block(10'h000);
      tick();
      check("t3_ovf_after", int'(ovf), 1);
      check("t3_head", int'($signed(pcm)), 8192);
      pcm_ready = 1'b1;
      repeat (6) tick();
      check("t3_valid_empty", int'(pcm_valid), 0);
      check("t3_pcm_empty", int'(pcm), 0);
      check("t3_drain", exp_q.size(), 0);

      // full FIFO with pop on the push edge, then clr_ovf against a drop
      do_reset();
      exp_q.push_back(8192);
      exp_q.push_back(8160);
      exp_q.push_back(2016);
      exp_q.push_back(16320);
      block(10'h100);
      block(10'h100);
      block(10'h040);
      block(10'h200);
      tick();
      repeat (7) sample(10'h000);
      exp_q.push_back(-128);
      sample(10'h000);
      pcm_ready = 1'b1;
      tick();
      pcm_ready = 1'b0;
      check("t4_no_drop_ovf", int'(ovf), 0);
      repeat (7) sample(10'h000);
      sample(10'h000);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("t4_drop_beats_clr", int'(ovf), 1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("t4_clr_ovf", int'(ovf), 0);
      pcm_ready = 1'b1;
      repeat (6) tick();
      check("t4_drain", exp_q.size(), 0);
      check("t4_valid_empty", int'(pcm_valid), 0);

      // reset mid-block discards the partial accumulation
      do_reset();
      pcm_ready = 1'b1;
      repeat (3) sample(10'd100);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
      repeat (7) sample(10'd200);
      repeat (3) tick();
      check("t5_no_early", int'(pcm_valid), 0);
      exp_q.push_back(6400);
      sample(10'd200);
      repeat (4) tick();
      check("t5_drain", exp_q.size(), 0);

      // full-scale constant for 4096 outputs: DC removal converges to ~0
      do_reset();
      pcm_ready = 1'b1;
      long_mode = 1'b1;
      cen = 1'b1;
      din = 10'h3FF;
      repeat (32768) @(posedge clk);
      #1;
      cen = 1'b0;
      repeat (4) tick();
      long_mode = 1'b0;
      check("t6_count", n_long, 4096);
      check("t6_first", first_pcm, 32736);
      check("t6_negative", neg_cnt, 0);
      check("t6_nonmonotonic", nonmono, 0);
      check("t6_final_small", int'(last_pcm <= 32 && last_pcm >= -32), 1);
      if (!(last_pcm <= 32 && last_pcm >= -32))
         $display("  t6 final pcm was %0d", last_pcm);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
